regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 82 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the address type for the multi-port register file.
// Optional same-cycle write-to-read bypass is selected by macro REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set by an issue, cleared by a write, issue wins on a tie.
// Looked up per read port with no same-cycle bypass.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD-1:0]        rbusy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // NOTE: combinational blocks use blocking assignments and start from a full
    // default, so every path assigns busy_d and no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (we0)    busy_d[wa0]      = 1'b0;
        if (we1)    busy_d[wa1]      = 1'b0;
        if (iss_en) busy_d[iss_addr] = 1'b1;  // a new producer outranks the retiring write
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rbusy
        assign rbusy[i] = busy_q[ra[i*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with a producer scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we0) mem_d[wa0] = wd0;
        if (we1) mem_d[wa1] = wd1;  // port 1 overrides port 0 on a shared address
        if (ZERO_REG != 0) mem_d[0] = '0;
    end

    // NOTE: the storage is flops, not a RAM macro, so it can take the async
    // reset and clear every register without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = ra[i*ADDR_W +: ADDR_W];

        always_comb begin
            val = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (!reset) begin
                if (we0 && wa0 == addr) val = wd0;
                if (we1 && wa1 == addr) val = wd1;
            end
`endif
            if (ZERO_REG != 0 && addr == '0) val = '0;
        end

        assign rd[i*DATA_W +: DATA_W] = val;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .we0      (we0),
        .wa0      (wa0),
        .we1      (we1),
        .wa1      (wa1),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .ra       (ra),
        .rbusy    (rbusy)
    );

endmodule
